// File: rtl/davinci_host_driver.sv
// davinci_host_driver
// Host-side stand-in for both DA-VinCi FIFOs. A small program memory is
// streamed into the instruction port one word per accept, while the
// dataout/dataAttrib stream is captured into a result buffer and EOV
// interrupts are acknowledged with clearEOV pulses.
// Optional feature: define DAVINCI_HOSTDRV_TIMEOUT_EN to add a watchdog that
// ends a stalled run after TIMEOUT_CYCLES cycles without progress.
module davinci_host_driver #(
    parameter int INSTR_WIDTH    = 30,
    parameter int DATA_WIDTH     = 16,
    parameter int ATTRIB_WIDTH   = 2,
    parameter int EOV_BIT        = 0,
    parameter int PROG_DEPTH     = 64,
    parameter int RES_DEPTH      = 256,
    parameter int TIMEOUT_CYCLES = 4096
) (
    input  logic                                 clk,
    input  logic                                 rst,
    input  logic                                 prog_we,
    input  logic [$clog2(PROG_DEPTH)-1:0]        prog_addr,
    input  logic [INSTR_WIDTH-1:0]               prog_wdata,
    input  logic                                 start,
    input  logic [$clog2(PROG_DEPTH):0]          prog_len,
    input  logic [15:0]                          expect_vecs,
    output logic                                 busy,
    output logic                                 done,
    output logic                                 timeout,
    output logic [INSTR_WIDTH-1:0]               instruction,
    output logic                                 instructionValid,
    input  logic                                 instructionNext,
    input  logic [DATA_WIDTH-1:0]                dataout,
    input  logic [ATTRIB_WIDTH-1:0]              dataAttrib,
    input  logic                                 dataoutValid,
    input  logic                                 eovInterrupt,
    output logic                                 clearEOV,
    input  logic [$clog2(RES_DEPTH)-1:0]         res_raddr,
    output logic [DATA_WIDTH+ATTRIB_WIDTH-1:0]   res_rdata,
    output logic [$clog2(RES_DEPTH):0]           res_count,
    output logic                                 overflow
);

    localparam int PA = $clog2(PROG_DEPTH);
    localparam int RA = $clog2(RES_DEPTH);
    localparam int RW = DATA_WIDTH + ATTRIB_WIDTH;
    localparam logic [RA:0] ResFull = (RA+1)'(RES_DEPTH);

    typedef enum logic [1:0] {IDLE, ISSUE, WAIT, DONE} stateT;

    stateT state;
    stateT nextState;

    logic [INSTR_WIDTH-1:0] progMem [PROG_DEPTH];
    logic [RW-1:0]          resBuf  [RES_DEPTH];

    logic [PA:0]  pc;
    logic [PA:0]  pcNext;
    logic [PA:0]  progLenReg;
    logic [15:0]  expectVecs;
    logic [15:0]  vecCnt;
    logic         launch;
    logic         accept;
    logic         issueLast;
    logic         capture;
    logic         bufFull;
    logic         isEov;
    logic         wdHit;

    assign launch    = (state == IDLE) && start;
    assign accept    = instructionValid && instructionNext;
    assign pcNext    = pc + (PA+1)'(1);
    assign issueLast = accept && (pcNext == progLenReg);
    assign capture   = busy && dataoutValid;
    assign bufFull   = (res_count == ResFull);
    assign isEov     = dataAttrib[EOV_BIT];

    // State register; reset drops straight back to IDLE so instructionValid falls asynchronously
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= nextState;
        end
    end

    // Next-state logic: issue the program, then wait for the expected number of vectors
    always_comb begin
        nextState = state;
        case (state)
            IDLE: begin
                if (start) begin
                    nextState = (prog_len != '0) ? ISSUE : WAIT;
                end
            end
            ISSUE: begin
                if (wdHit) begin
                    nextState = DONE;
                end else if (issueLast) begin
                    nextState = WAIT;
                end
            end
            WAIT: begin
                if (wdHit || (vecCnt >= expectVecs)) begin
                    nextState = DONE;
                end
            end
            DONE: begin
                nextState = IDLE;
            end
            default: begin
                nextState = IDLE;
            end
        endcase
    end

    // Status outputs decoded from the current state only
    always_comb begin
        busy             = (state == ISSUE) || (state == WAIT);
        done             = (state == DONE);
        instructionValid = (state == ISSUE);
    end

    // Program memory write port; locked while a run is using it
    always_ff @(posedge clk) begin
        if (prog_we && (state == IDLE)) begin
            progMem[prog_addr] <= prog_wdata;
        end
    end

    // Run bookkeeping: program counter with prefetch of the next word, vector and capture counters
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pc          <= '0;
            progLenReg  <= '0;
            expectVecs  <= '0;
            vecCnt      <= '0;
            res_count   <= '0;
            overflow    <= 1'b0;
            instruction <= '0;
        end else if (launch) begin
            pc          <= '0;
            progLenReg  <= prog_len;
            expectVecs  <= expect_vecs;
            vecCnt      <= '0;
            res_count   <= '0;
            overflow    <= 1'b0;
            if (prog_len != '0) begin
                instruction <= progMem[0];
            end
        end else begin
            if (accept) begin
                pc          <= pcNext;
                instruction <= progMem[pcNext[PA-1:0]];
            end
            if (capture) begin
                if (isEov) begin
                    vecCnt <= vecCnt + 16'd1;
                end
                if (bufFull) begin
                    overflow <= 1'b1;
                end else begin
                    res_count <= res_count + (RA+1)'(1);
                end
            end
        end
    end

    // Result buffer write port; words beyond the buffer size are dropped
    always_ff @(posedge clk) begin
        if (capture && !bufFull) begin
            resBuf[res_count[RA-1:0]] <= {dataAttrib, dataout};
        end
    end

    // Registered result read port
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            res_rdata <= '0;
        end else begin
            res_rdata <= resBuf[res_raddr];
        end
    end

    // EOV acknowledge: pulse once, then stay low for a cycle so a held interrupt gets every other cycle
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            clearEOV <= 1'b0;
        end else begin
            clearEOV <= eovInterrupt && !clearEOV;
        end
    end

`ifdef DAVINCI_HOSTDRV_TIMEOUT_EN
    localparam int WW = $clog2(TIMEOUT_CYCLES + 1);

    logic [WW-1:0] wdCnt;
    logic          progress;

    assign progress = accept || dataoutValid;
    assign wdHit    = busy && !progress && (wdCnt == WW'(TIMEOUT_CYCLES - 1));

    // Watchdog: counts cycles without an accept or a data word, and flags a stalled run
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wdCnt   <= '0;
            timeout <= 1'b0;
        end else if (launch) begin
            wdCnt   <= '0;
            timeout <= 1'b0;
        end else if (busy) begin
            if (progress) begin
                wdCnt <= '0;
            end else if (wdHit) begin
                timeout <= 1'b1;
            end else begin
                wdCnt <= wdCnt + WW'(1);
            end
        end
    end
`else
    assign wdHit   = 1'b0;
    assign timeout = 1'b0;
`endif

endmodule

// File: tb/tb_davinci_host_driver.sv
// tb_davinci_host_driver
// Randomized bench for davinci_host_driver with a cycle-level reference model
// of the host protocol (program order, run completion, capture, EOV acknowledge).
module tb_davinci_host_driver;

    localparam int IW = 30;
    localparam int DW = 16;
    localparam int AW = 2;
    localparam int PD = 16;
    localparam int RD = 8;
    localparam int TC = 16;
    localparam int PA = $clog2(PD);
    localparam int RA = $clog2(RD);

    logic               clk = 1'b0;
    logic               rst;
    logic               prog_we;
    logic [PA-1:0]      prog_addr;
    logic [IW-1:0]      prog_wdata;
    logic               start;
    logic [PA:0]        prog_len;
    logic [15:0]        expect_vecs;
    logic               busy;
    logic               done;
    logic               timeout;
    logic [IW-1:0]      instruction;
    logic               instructionValid;
    logic               instructionNext;
    logic [DW-1:0]      dataout;
    logic [AW-1:0]      dataAttrib;
    logic               dataoutValid;
    logic               eovInterrupt;
    logic               clearEOV;
    logic [RA-1:0]      res_raddr;
    logic [DW+AW-1:0]   res_rdata;
    logic [RA:0]        res_count;
    logic               overflow;

    int checks = 0;
    int fails  = 0;

    logic [IW-1:0]    progModel [PD];
    logic [DW+AW-1:0] wordQ[$];
    logic [DW+AW-1:0] expBuf[$];

    logic expClear = 1'b0;
    logic prevEov  = 1'b0;

    davinci_host_driver #(
        .INSTR_WIDTH(IW), .DATA_WIDTH(DW), .ATTRIB_WIDTH(AW), .EOV_BIT(0),
        .PROG_DEPTH(PD), .RES_DEPTH(RD), .TIMEOUT_CYCLES(TC)
    ) dut (
        .clk(clk), .rst(rst),
        .prog_we(prog_we), .prog_addr(prog_addr), .prog_wdata(prog_wdata),
        .start(start), .prog_len(prog_len), .expect_vecs(expect_vecs),
        .busy(busy), .done(done), .timeout(timeout),
        .instruction(instruction), .instructionValid(instructionValid),
        .instructionNext(instructionNext),
        .dataout(dataout), .dataAttrib(dataAttrib), .dataoutValid(dataoutValid),
        .eovInterrupt(eovInterrupt), .clearEOV(clearEOV),
        .res_raddr(res_raddr), .res_rdata(res_rdata),
        .res_count(res_count), .overflow(overflow)
    );

    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input logic [63:0] actual, input logic [63:0] expected);
        checks++;
        if (actual !== expected) begin
            fails++;
            $display("[TB] FAIL %s: got %0h, expected %0h", tag, actual, expected);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // EOV acknowledge model: a pulse follows any interrupt cycle that did not itself carry a pulse
    always @(negedge clk) begin
        if (rst) begin
            expClear = 1'b0;
            prevEov  = 1'b0;
        end else begin
            expClear = prevEov && !expClear;
            checkOutput("clearEOV", clearEOV, expClear);
            prevEov = eovInterrupt;
        end
    end

    task automatic loadProgram(input int len);
        for (int i = 0; i < len; i++) begin
            progModel[i] = IW'($urandom());
            prog_we    = 1'b1;
            prog_addr  = PA'(i);
            prog_wdata = progModel[i];
            step();
        end
        prog_we = 1'b0;
    endtask

    task automatic applyStimulus(input int len, input int expVecs, input int nextMode, input string name);
        int accIdx;
        int vecs;
        int sentIdx;
        int ready;
        bit finished;
        bit nextVal;
        bit sendNow;
        bit expValid;
        logic [DW+AW-1:0] w;

        loadProgram(len);
        accIdx   = 0;
        vecs     = 0;
        sentIdx  = 0;
        ready    = -1;
        finished = 1'b0;
        expBuf.delete();

        for (int c = 0; c < 400; c++) begin
            start       = (c == 0);
            prog_len    = (PA+1)'(len);
            expect_vecs = 16'(expVecs);
            case (nextMode)
                0:       nextVal = 1'b1;
                1:       nextVal = (((c - 1) % 2) == 0);
                default: nextVal = 1'($urandom_range(1, 0));
            endcase
            instructionNext = nextVal;
            sendNow = (c >= 1) && (sentIdx < wordQ.size()) && ($urandom_range(1, 0) == 1);
            w = sendNow ? wordQ[sentIdx] : (DW+AW)'($urandom());
            dataoutValid = sendNow;
            {dataAttrib, dataout} = w;
            eovInterrupt = ($urandom_range(3, 0) == 0);
            prog_we    = (c == 1);
            prog_addr  = PA'($urandom());
            prog_wdata = IW'($urandom());

            @(negedge clk);
            expValid = (c >= 1) && (accIdx < len);
            checkOutput({name, ".instructionValid"}, instructionValid, expValid);
            if (expValid) begin
                checkOutput({name, ".instruction"}, instruction, progModel[accIdx]);
            end
            checkOutput({name, ".busy"}, busy, (c >= 1) && !((ready >= 0) && (c >= ready + 2)));
            checkOutput({name, ".done"}, done, (ready >= 0) && (c == ready + 2));

            if (expValid && nextVal) begin
                accIdx++;
            end
            if (sendNow) begin
                if (expBuf.size() < RD) begin
                    expBuf.push_back(w);
                end
                if (w[DW]) begin
                    vecs++;
                end
                sentIdx++;
            end
            if ((ready < 0) && (accIdx == len) && (vecs >= expVecs)) begin
                ready = c;
            end
            if ((ready >= 0) && (c == ready + 2)) begin
                finished = 1'b1;
                break;
            end
            @(posedge clk);
            #1;
        end
        checkOutput({name, ".runCompleted"}, finished, 1'b1);

        start           = 1'b0;
        prog_we         = 1'b0;
        dataoutValid    = 1'b0;
        eovInterrupt    = 1'b0;
        instructionNext = 1'b0;
        step();
        checkOutput({name, ".idleBusy"}, busy, 1'b0);
        checkOutput({name, ".resCount"}, res_count, expBuf.size());
        checkOutput({name, ".overflow"}, overflow, (sentIdx > RD));
        checkOutput({name, ".accepts"}, accIdx, len);
        for (int i = 0; i < expBuf.size(); i++) begin
            res_raddr = RA'(i);
            step();
            checkOutput($sformatf("%s.buf%0d", name, i), res_rdata, expBuf[i]);
        end
    endtask

    task automatic makeRandomWords(output int nEov);
        int n;
        logic [DW+AW-1:0] w;
        wordQ.delete();
        nEov = 0;
        n = $urandom_range(6, 1);
        for (int i = 0; i < n; i++) begin
            w = (DW+AW)'($urandom());
            if (i == n - 1) begin
                w[DW] = 1'b1;
            end
            if (w[DW]) begin
                nEov++;
            end
            wordQ.push_back(w);
        end
    endtask

    initial begin
        int nEov;
        int pulses;

        rst = 1'b1;
        prog_we = 1'b0; prog_addr = '0; prog_wdata = '0;
        start = 1'b0; prog_len = '0; expect_vecs = '0;
        instructionNext = 1'b0; dataout = '0; dataAttrib = '0; dataoutValid = 1'b0;
        eovInterrupt = 1'b0; res_raddr = '0;
        step();
        step();
        checkOutput("reset.busy", busy, 1'b0);
        checkOutput("reset.done", done, 1'b0);
        checkOutput("reset.instructionValid", instructionValid, 1'b0);
        checkOutput("reset.instruction", instruction, '0);
        checkOutput("reset.clearEOV", clearEOV, 1'b0);
        checkOutput("reset.resCount", res_count, '0);
        checkOutput("reset.overflow", overflow, 1'b0);
        checkOutput("reset.timeout", timeout, 1'b0);
        checkOutput("reset.resRdata", res_rdata, '0);
        rst = 1'b0;
        step();

        wordQ.delete();
        applyStimulus(4, 0, 0, "seq4");
        applyStimulus(4, 0, 1, "toggle4");

        wordQ.delete();
        wordQ.push_back({2'b10, 16'h1111});
        wordQ.push_back({2'b00, 16'h2222});
        wordQ.push_back({2'b01, 16'h3333});
        wordQ.push_back({2'b10, 16'h4444});
        wordQ.push_back({2'b11, 16'h5555});
        applyStimulus($urandom_range(8, 1), 2, 2, "vec2");

        // Held interrupt burst: five high cycles must give three acknowledges
        pulses = 0;
        for (int i = 0; i < 8; i++) begin
            eovInterrupt = (i < 5);
            step();
            if (clearEOV) begin
                pulses++;
            end
        end
        checkOutput("eovBurst.pulses", pulses, 3);

        wordQ.delete();
        for (int i = 0; i < 11; i++) begin
            wordQ.push_back({(i == 10) ? 2'b01 : 2'($urandom_range(1, 0) * 2), 16'($urandom())});
        end
        applyStimulus(3, 1, 2, "ovf");

        // Reset in the middle of issuing
        loadProgram(8);
        prog_len = 5'd8; expect_vecs = 16'd0; instructionNext = 1'b0; start = 1'b1;
        step();
        start = 1'b0;
        step();
        step();
        checkOutput("midReset.busyBefore", busy, 1'b1);
        rst = 1'b1;
        #1;
        checkOutput("midReset.busy", busy, 1'b0);
        checkOutput("midReset.instructionValid", instructionValid, 1'b0);
        checkOutput("midReset.overflow", overflow, 1'b0);
        checkOutput("midReset.resCount", res_count, '0);
        step();
        rst = 1'b0;
        step();
        checkOutput("midReset.idle", busy, 1'b0);

        wordQ.delete();
        applyStimulus(0, 0, 2, "empty");

        for (int r = 0; r < 6; r++) begin
            makeRandomWords(nEov);
            applyStimulus($urandom_range(PD, 0), nEov, 2, $sformatf("rand%0d", r));
        end

`ifdef DAVINCI_HOSTDRV_TIMEOUT_EN
        // Stalled run: nothing arrives, watchdog ends it after TC quiet cycles
        prog_len = '0; expect_vecs = 16'd1; start = 1'b1;
        for (int c = 0; c < 20; c++) begin
            start = (c == 0);
            @(negedge clk);
            checkOutput("timeout.done", done, (c == TC + 1));
            checkOutput("timeout.flag", timeout, (c >= TC + 1));
            @(posedge clk);
            #1;
        end
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end

endmodule
